// File: rtl/seed_noise_feeder_if.sv
// seed_noise_feeder_if
// Groups the feeder's control, seed-FIFO and generator signals into one bundle.
//   master : the feeder (drives seed_wr_*, gen_start, busy, done, err, batch_count)
//   slave  : the surrounding pipeline (drives request, seed_load/value, seed_full,
//            seed_level, gen_busy, gen_done)
//
// Handshakes: seed_wr_en is a one-cycle write strobe that is only raised when
// seed_full was low on the edge that produced it, so a word is never offered to
// a full FIFO and is never repeated. gen_start is held high level-style until
// gen_busy is sampled high; the generator's acceptance is gen_busy itself.
interface seed_noise_feeder_if;
  logic        request;
  logic        seed_load;
  logic [15:0] seed_value;
  logic        seed_wr_en;
  logic [15:0] seed_wr_data;
  logic        seed_full;
  logic [6:0]  seed_level;
  logic        gen_start;
  logic        gen_busy;
  logic        gen_done;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] batch_count;

  modport master (
    input  request, seed_load, seed_value, seed_full, seed_level, gen_busy, gen_done,
    output seed_wr_en, seed_wr_data, gen_start, busy, done, err, batch_count
  );

  modport slave (
    output request, seed_load, seed_value, seed_full, seed_level, gen_busy, gen_done,
    input  seed_wr_en, seed_wr_data, gen_start, busy, done, err, batch_count
  );
endinterface

// File: rtl/seed_noise_feeder.sv
// seed_noise_feeder
// On request, writes SEED_COUNT scaled LFSR words (signed Q8.8) into the
// generator's seed FIFO, kicks the generator, waits for it and reports done.
// The LFSR state persists across batches so every batch is a fresh vector.
// Ports:
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   bus         : seed_noise_feeder_if.master (request/seed/FIFO/generator/status)
//   dbg_state_o : current FSM state, for observation only
module seed_noise_feeder #(
  parameter int          SEED_COUNT  = 64,
  parameter int          SCALE_SHIFT = 2,
  parameter logic [15:0] RESET_SEED  = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seed_noise_feeder_if.master  bus,
  output logic [2:0]           dbg_state_o
);

  localparam int CW = $clog2(SEED_COUNT + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_KICK = 3'd2,
    S_WAIT = 3'd3,
    S_FIN  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        gen_start_q, gen_start_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [15:0] bc_q, bc_d;

  // Fibonacci taps 16,14,13,11.
  logic        lfsr_fb;
  logic signed [15:0] scaled_word;
  assign lfsr_fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign scaled_word = $signed(lfsr_q) >>> SCALE_SHIFT;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lfsr_d      = lfsr_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    gen_start_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    bc_d        = bc_q;

    case (state_q)
      S_IDLE: begin
        // Load lands in lfsr_d, so a same-cycle request starts from the new seed.
        if (bus.seed_load) begin
          lfsr_d = (bus.seed_value == 16'd0) ? RESET_SEED : bus.seed_value;
        end
        if (bus.request) begin
          // Leftover words in the FIFO would shift the whole seed vector.
          if (bus.seed_level == 7'd0) begin
            state_d = S_FILL;
            cnt_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        if (!bus.seed_full) begin
          wr_en_d   = 1'b1;
          wr_data_d = scaled_word;
          lfsr_d    = {lfsr_q[14:0], lfsr_fb};
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CW'(SEED_COUNT - 1)) begin
            state_d = S_KICK;
          end
        end
      end
      S_KICK: begin
        if (bus.gen_busy) begin
          // A done coincident with busy must not be lost.
          state_d = bus.gen_done ? S_FIN : S_WAIT;
        end else begin
          gen_start_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.gen_done) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        bc_d    = bc_q + 16'd1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lfsr_q      <= RESET_SEED;
      wr_en_q     <= 1'b0;
      wr_data_q   <= 16'd0;
      gen_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      bc_q        <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lfsr_q      <= lfsr_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      gen_start_q <= gen_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      bc_q        <= bc_d;
    end
  end

  assign bus.seed_wr_en   = wr_en_q;
  assign bus.seed_wr_data = wr_data_q;
  assign bus.gen_start    = gen_start_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.batch_count  = bc_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_seed_noise_feeder.sv
module tb_seed_noise_feeder;

  localparam int SEED_COUNT = 64;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic [2:0] dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  seed_noise_feeder_if bus();

  seed_noise_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int n_checks;
  int n_errors;
  int wr_total;
  logic [15:0] model_lfsr;
  int model_bc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // LFSR step from the tap rule using integer arithmetic.
  function automatic logic [15:0] model_next(input logic [15:0] l);
    int v, fb, n;
    v  = int'(l);
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    n  = ((v * 2) + fb) % 65536;
    return n[15:0];
  endfunction

  // Signed value divided by 4 with rounding toward minus infinity.
  function automatic logic [15:0] model_word(input logic [15:0] l);
    int s, q;
    s = (int'(l) >= 32768) ? int'(l) - 65536 : int'(l);
    q = (s >= 0) ? s / 4 : -((-s + 3) / 4);
    return q[15:0];
  endfunction

  // ---------------- driver / monitor ----------------
  // One clock; inputs set before the call are seen at this edge; outputs are
  // observed 1 time unit after the edge.
  task automatic tick();
    logic f;
    f = bus.seed_full;
    @(posedge clk);
    #1;
    if (bus.seed_wr_en) begin
      wr_total++;
      got_q.push_back(bus.seed_wr_data);
      check("wr_while_full", {31'd0, f}, 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got %0h, expected no write", bus.seed_wr_data);
      end else begin
        check("seed_word", {16'd0, bus.seed_wr_data}, {16'd0, exp_q.pop_front()});
      end
    end
  endtask

  task automatic run_batch(input bit load, input logic [15:0] sv, input int bp,
                           input int stall_at, input int stall_len, input bit poke,
                           input int busy_delay, input int done_delay, input int exp_cycles);
    int start, cycles, stalled, n, hi;
    bit poked, poke_now;
    got_q.delete();
    if (load) model_lfsr = (sv == 16'd0) ? 16'hACE1 : sv;
    for (int i = 0; i < SEED_COUNT; i++) begin
      exp_q.push_back(model_word(model_lfsr));
      model_lfsr = model_next(model_lfsr);
    end

    bus.seed_level = 7'd0;
    bus.request    = 1'b1;
    bus.seed_load  = load;
    bus.seed_value = sv;
    tick();
    bus.request   = 1'b0;
    bus.seed_load = 1'b0;
    check("busy_on_accept", {31'd0, bus.busy}, 32'd1);
    check("err_on_accept", {31'd0, bus.err}, 32'd0);

    start = wr_total; cycles = 0; stalled = 0; poked = 0;
    while ((wr_total - start) < SEED_COUNT && cycles < 2000) begin
      n = wr_total - start;
      poke_now = 1'b0;
      if (stall_len > 0 && n == stall_at && stalled < stall_len) begin
        bus.seed_full = 1'b1;
        stalled++;
      end else begin
        bus.seed_full = ($urandom_range(0, 99) < bp);
      end
      if (poke && n == 10 && !poked) begin
        bus.request    = 1'b1;
        bus.seed_load  = 1'b1;
        bus.seed_value = 16'h1234;
        poked    = 1'b1;
        poke_now = 1'b1;
      end
      tick();
      cycles++;
      bus.request   = 1'b0;
      bus.seed_load = 1'b0;
      if (poke_now) check("err_ignored_in_fill", {31'd0, bus.err}, 32'd0);
    end
    bus.seed_full = 1'b0;
    check("write_count", wr_total - start, SEED_COUNT);
    check("exp_q_drained", exp_q.size(), 0);
    if (exp_cycles >= 0) check("fill_cycles", cycles, exp_cycles);

    tick();
    check("gen_start_after_fill", {31'd0, bus.gen_start}, 32'd1);
    hi = 1;
    for (int i = 1; i < busy_delay; i++) begin
      tick();
      if (bus.gen_start) hi++;
    end
    check("gen_start_hold", hi, busy_delay);
    bus.gen_busy = 1'b1;
    if (done_delay == 0) bus.gen_done = 1'b1;
    tick();
    bus.gen_done = 1'b0;
    check("gen_start_drop", {31'd0, bus.gen_start}, 32'd0);
    if (done_delay > 0) begin
      for (int i = 1; i < done_delay; i++) tick();
      check("done_before_gen_done", {31'd0, bus.done}, 32'd0);
      bus.gen_done = 1'b1;
      bus.gen_busy = 1'b0;
      tick();
      bus.gen_done = 1'b0;
    end else begin
      bus.gen_busy = 1'b0;
    end
    check("done_not_early", {31'd0, bus.done}, 32'd0);
    tick();
    model_bc = (model_bc + 1) % 65536;
    check("done_pulse", {31'd0, bus.done}, 32'd1);
    check("batch_count", {16'd0, bus.batch_count}, model_bc);
    check("busy_after_done", {31'd0, bus.busy}, 32'd0);
    tick();
    check("done_single", {31'd0, bus.done}, 32'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          load;
    logic [15:0] seed;
    logic [15:0] w0;
    logic [15:0] w1;
    int          busy_d;
    int          done_d;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int start;
    vecs[0] = '{1'b0, 16'h0000, 16'hEB38, 16'h1670, 10, 500};
    vecs[1] = '{1'b1, 16'h0000, 16'hEB38, 16'h1670, 2, 3};
    vecs[2] = '{1'b1, 16'h0001, 16'h0000, 16'h0000, 3, 1};
    vecs[3] = '{1'b1, 16'h8000, 16'hE000, 16'h0000, 1, 7};
    vecs[4] = '{1'b1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 1, 0};

    n_checks = 0; n_errors = 0; wr_total = 0;
    model_lfsr = 16'hACE1; model_bc = 0;

    rst_n = 1'b0;
    bus.request = 1'b0; bus.seed_load = 1'b0; bus.seed_value = 16'd0;
    bus.seed_full = 1'b0; bus.seed_level = 7'd0;
    bus.gen_busy = 1'b0; bus.gen_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", {31'd0, bus.seed_wr_en}, 32'd0);
    check("rst_gen_start", {31'd0, bus.gen_start}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_batch_count", {16'd0, bus.batch_count}, 32'd0);
    check("rst_state", {29'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table: seed handling and generator handshake timing.
    for (int i = 0; i < 5; i++) begin
      run_batch(vecs[i].load, vecs[i].seed, 0, 0, 0, 1'b0,
                vecs[i].busy_d, vecs[i].done_d, SEED_COUNT);
      if (got_q.size() < 2) begin
        check("row_word_count", got_q.size(), 2);
      end else begin
        check("row_w0", {16'd0, got_q[0]}, {16'd0, vecs[i].w0});
        check("row_w1", {16'd0, got_q[1]}, {16'd0, vecs[i].w1});
      end
    end

    // Backpressure for 5 cycles at word 20.
    run_batch(1'b0, 16'd0, 0, 20, 5, 1'b0, 2, 4, SEED_COUNT + 5);

    // request / seed_load during FILL are ignored.
    run_batch(1'b0, 16'd0, 0, 0, 0, 1'b1, 3, 2, SEED_COUNT);

    // Rejected request with stale words in the FIFO.
    start = wr_total;
    bus.seed_level = 7'd3;
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
    check("err_pulse", {31'd0, bus.err}, 32'd1);
    check("err_busy", {31'd0, bus.busy}, 32'd0);
    tick();
    check("err_single", {31'd0, bus.err}, 32'd0);
    bus.seed_level = 7'd0;
    repeat (4) tick();
    check("err_no_writes", wr_total - start, 0);
    check("err_still_idle", {31'd0, bus.busy}, 32'd0);

    // Randomized batches against the model.
    for (int r = 0; r < 4; r++) begin
      logic [15:0] sv;
      sv = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(0, 65535));
      run_batch(1'($urandom_range(0, 1)), sv, 30, 0, 0, 1'b0,
                $urandom_range(1, 6), $urandom_range(0, 20), -1);
    end

    // Reset in the middle of FILL.
    got_q.delete();
    for (int i = 0; i < SEED_COUNT; i++) begin
      exp_q.push_back(model_word(model_lfsr));
      model_lfsr = model_next(model_lfsr);
    end
    start = wr_total;
    bus.request = 1'b1;
    tick();
    bus.request = 1'b0;
    for (int c = 0; c < 200 && (wr_total - start) < 30; c++) tick();
    check("pre_reset_writes", wr_total - start, 30);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_en", {31'd0, bus.seed_wr_en}, 32'd0);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_gen_start", {31'd0, bus.gen_start}, 32'd0);
    check("midrst_batch_count", {16'd0, bus.batch_count}, 32'd0);
    check("midrst_state", {29'd0, dbg_state}, 32'd0);
    exp_q.delete();
    model_lfsr = 16'hACE1;
    model_bc = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    run_batch(1'b0, 16'd0, 0, 0, 0, 1'b0, 2, 5, SEED_COUNT);
    if (got_q.size() < 1) check("post_reset_word_count", got_q.size(), 1);
    else check("post_reset_w0", {16'd0, got_q[0]}, 32'h0000EB38);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
